// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, arbiter state and aux entry type for the regfile write arbiter
package rf_pkg;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  typedef enum logic {INIT, RUN} arb_state_t;
  typedef struct packed {
    logic                 live;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } aux_entry_t;
endpackage

// File: rtl/rf_aux_fifo.sv
// rf_aux_fifo: aux result buffer with push/pop/count and per-address kill of buffered entries
//   push_i/push_addr_i/push_data_i enqueue a live entry; pop_i drops the head
//   kill_en_i/kill_addr_i clear the live bit of entries already held with that address
//   head_*_o expose the oldest entry; count_o is occupancy
module rf_aux_fifo #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [ADDR_W-1:0]        push_addr_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  input  logic                     kill_en_i,
  input  logic [ADDR_W-1:0]        kill_addr_i,
  output logic                     head_live_o,
  output logic [ADDR_W-1:0]        head_addr_o,
  output logic [DATA_W-1:0]        head_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  logic              live_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [PW:0]       cnt_q, cnt_d;
  assign cnt_d       = cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
  assign count_o     = cnt_q;
  assign head_live_o = live_q[rd_q];
  assign head_addr_o = addr_q[rd_q];
  assign head_data_o = data_q[rd_q];
  // Kill first so an entry pushed on the same edge (younger than the wb write) stays live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (kill_en_i && addr_q[i] == kill_addr_i) live_q[i] <= 1'b0;
    if (push_i) begin
      live_q[wr_q] <= 1'b1;
      addr_q[wr_q] <= push_addr_i;
      data_q[wr_q] <= push_data_i;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between writeback and a buffered aux unit
//   wb_*      writeback request, always wins in RUN, zero-latency pass-through
//   aux_*     valid/ready handshake into rf_aux_fifo; aux_count is occupancy
//   init_busy high while the post-reset zero sweep runs
//   rf_*      drive WE3/A3/WD3 of the register file
//   rst       asynchronous active-low reset
//   Macro RFARB_CLEAR_ON_RESET_EN enables the INIT sweep; without it reset lands directly in RUN.
module regfile_write_arbiter import rf_pkg::*; #(
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DATA_W    = RF_DATA_W,
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_we,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       aux_valid,
  output logic                       aux_ready,
  input  logic [ADDR_W-1:0]          aux_addr,
  input  logic [DATA_W-1:0]          aux_data,
  output logic                       init_busy,
  output logic [$clog2(BUF_DEPTH):0] aux_count,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_addr,
  output logic [DATA_W-1:0]          rf_wdata
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  if (NUM_REGS > 2**ADDR_W) $error("NUM_REGS exceeds address space");
  logic              run, wb_hit, pop, push, head_live;
  logic [ADDR_W-1:0] sweep_q, head_addr;
  logic [DATA_W-1:0] head_data;
`ifdef RFARB_CLEAR_ON_RESET_EN
  arb_state_t state_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else if (state_q == INIT) begin
      sweep_q <= sweep_q + 1'b1;
      if (sweep_q == ADDR_W'(NUM_REGS - 1)) state_q <= RUN;
    end
  end
  assign run       = state_q == RUN;
  assign init_busy = !run;
`else
  assign sweep_q   = '0;
  assign run       = 1'b1;
  assign init_busy = 1'b0;
`endif
  assign wb_hit    = run && wb_we && wb_addr != '0;
  assign pop       = run && !wb_hit && aux_count != '0;
  // Ready looks only at registered occupancy: a full buffer never takes a same-cycle pass-through.
  assign aux_ready = rst && run && aux_count != CW'(BUF_DEPTH);
  // x0 results complete the handshake but are dropped instead of buffered.
  assign push      = aux_valid && aux_ready && aux_addr != '0;
  assign rf_we     = rst && (!run || wb_hit || (pop && head_live));
  assign rf_addr   = !run ? sweep_q : wb_hit ? wb_addr : pop ? head_addr : '0;
  assign rf_wdata  = !run ? '0 : wb_hit ? wb_data : pop ? head_data : '0;
  rf_aux_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_addr_i (aux_addr),
    .push_data_i (aux_data),
    .pop_i       (pop),
    .kill_en_i   (wb_hit),
    .kill_addr_i (wb_addr),
    .head_live_o (head_live),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (aux_count)
  );
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Controls and shares the single register-file write port (WE3/A3/WD3) between two requesters.
  - The pipeline writeback stage always wins the port.
  - A multi-cycle unit (divider or slow load path) uses a valid/ready handshake into a small buffer.
- After reset, optionally sweeps every register to zero before normal operation starts.
- Sits between writeback and the register file, and drives the file's write port directly.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- NUM_REGS, 32, registers swept during init (must be 2**ADDR_W or less)
- BUF_DEPTH, 2, aux buffer entries (power of two, 2 or more)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- wb_we  in  1  writeback write request; no ready, always serviced in RUN
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- aux_valid  in  1  multi-cycle unit result valid
- aux_ready  out  1  buffer can accept aux result
- aux_addr  in  ADDR_W  aux destination
- aux_data  in  DATA_W  aux data
- init_busy  out  1  init sweep in progress; pipeline must stall
- aux_count  out  $clog2(BUF_DEPTH)+1  occupied buffer entries
- rf_we  out  1  to register file WE3
- rf_addr  out  ADDR_W  to A3
- rf_wdata  out  DATA_W  to WD3

Behaviour:
- States: INIT, RUN.
- While rst=0:
  - state returns to INIT, sweep counter is 0, buffer is empty.
  - aux_ready=0, rf_we=0, aux_count=0; init_busy=1.
- INIT:
  - Each cycle: rf_we=1, rf_addr=sweep counter, rf_wdata=0; counter increments.
  - After the write to address NUM_REGS-1, go to RUN. INIT lasts exactly NUM_REGS cycles.
  - aux_ready=0 throughout. wb_we is ignored; asserting it is a protocol violation.
- RUN:
  - init_busy=0.
  - aux_ready = (aux_count != BUF_DEPTH), based on registered state only. There is no same-cycle pass-through when full.
- Writes to x0:
  - wb_we with wb_addr=0 produces rf_we=0.
  - An aux handshake with aux_addr=0 is accepted and discarded, never enqueued.
- Arbitration, each RUN cycle:
  - wb_we=1 and wb_addr!=0: rf_we=1, rf_addr/rf_wdata = wb fields, combinational (0-cycle latency).
  - Otherwise, if the buffer is non-empty: pop the head; rf_we = head.live, rf_addr/rf_wdata = head fields.
  - Otherwise rf_we=0, and rf_addr/rf_wdata hold 0.
- Aux acceptance:
  - aux_valid & aux_ready enqueues {live=1, addr, data} at the clock edge.
  - Earliest write of that entry is the next cycle, so minimum aux latency is 1.
- Simultaneous push and pop: permitted; aux_count is unchanged.
- WAW protection:
  - A wb write to address A clears the live bit of every entry that was already in the buffer at the start of that cycle with addr==A.
  - An aux entry enqueued in the same cycle is younger and keeps live=1.
  - Killed entries still pop in order, one per cycle, with rf_we=0.
- Order: buffer is FIFO; pointers wrap modulo BUF_DEPTH.
- Starvation: with back-to-back wb writes, aux entries wait indefinitely. aux_ready drops once the buffer is full, and that is the only back-pressure.
- Reset asserted mid-operation: buffered entries are lost; the sweep restarts at 0 after reset is released.

Optional Feature:
- Macro: RFARB_CLEAR_ON_RESET_EN.
- Defined: the INIT sweep is as described above.
- Undefined:
  - There is no INIT state or sweep counter; reset lands in RUN.
  - init_busy is tied to 0.
  - During reset, aux_ready and rf_we are still 0.
  - Register contents remain whatever the register file's initial block supplies.

Decomposition:
- Shared package rf_pkg holds:
  - RF_ADDR_W=5, RF_DATA_W=32, RF_NUM_REGS=32.
  - arb_state_t enum {INIT, RUN}.
  - aux_entry_t struct {live, addr, data}.
- One sub-module is natural: rf_aux_fifo.
  - BUF_DEPTH entries with push, pop, and count.
  - Per-entry kill input: kill_en plus kill_addr, which clears the live bit on matching occupied entries.

Test Plan:
- Reset released, macro on: 32 cycles of rf_we=1, rf_addr 0..31, rf_wdata=0, init_busy=1. Cycle 33: init_busy=0, aux_ready=1.
- Aux write alone: aux x5=0x12345678 accepted in cycle N -> cycle N+1 rf_we=1, rf_addr=5, rf_wdata=0x12345678; aux_count goes 1 then 0.
- Contention:
  - Stimulus: aux x7=0x7 and x9=0x9 accepted while wb writes x3 every cycle for 4 cycles.
  - Response: aux_count reaches 2 and aux_ready=0. Once wb goes idle, x7 is written, then x9, on consecutive cycles.
- WAW kill:
  - Stimulus: x9=0xAAAA buffered, then wb writes x9=0x1.
  - Response: the later pop of the x9 entry shows rf_we=0. A final read of x9 returns 0x1.
- x0 handling: wb_we with wb_addr=0 -> rf_we=0. Aux with aux_addr=0 -> accepted, aux_count stays 0, no write.
- Mid-operation reset: rst pulsed low with 2 entries buffered -> aux_count=0, sweep restarts at address 0, and no buffered entry is ever written.
